// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle bounding-box tracker.
// Colour encodings, the bounding-box record, tracker FSM states and
// centre-point helpers live here so the top and the accumulator agree.
package paddle_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int ROW_W = 11;
  localparam int COL_W = 12;

  localparam logic [1:0] ENC_NONE = 2'b00;
  localparam logic [1:0] ENC_C1   = 2'b01;
  localparam logic [1:0] ENC_C2   = 2'b10;
  localparam logic [1:0] ENC_BOTH = 2'b11;

  typedef struct packed {
    logic [ROW_W-1:0] row_min;
    logic [ROW_W-1:0] row_max;
    logic [COL_W-1:0] col_min;
    logic [COL_W-1:0] col_max;
  } bbox_t;

  localparam int BBOX_W = $bits(bbox_t);

  // Empty box: min at all-ones and max at zero so the first hit wins both.
  localparam bbox_t BBOX_EMPTY = {{ROW_W{1'b1}}, {ROW_W{1'b0}},
                                  {COL_W{1'b1}}, {COL_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } tracker_state_t;

  // Midpoint with one guard bit so min+max cannot wrap.
  function automatic logic [ROW_W-1:0] mid_row(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ROW_W:1];
  endfunction

  function automatic logic [COL_W-1:0] mid_col(input logic [COL_W-1:0] a,
                                               input logic [COL_W-1:0] b);
    logic [COL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COL_W:1];
  endfunction

endpackage

// File: rtl/paddle_bbox_tracker_bbox_accum.sv
// Per-colour bounding-box accumulator: running row/col min/max and a
// saturating hit counter. 'first' restarts the box with the current pixel,
// 'clear' empties it, 'hit' folds the current pixel in.
module bbox_accum
  import paddle_pkg::*;
#(
  parameter int CNT_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              first,
  input  logic              hit,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [BBOX_W-1:0] bbox,
  output logic [CNT_W-1:0]  count
);

  bbox_t            bbox_reg, bbox_next, bbox_base;
  logic [CNT_W-1:0] count_reg, count_next, count_base;

  // Choose the starting point (fresh or running) then fold in a hit.
  always_comb begin
    bbox_base  = (clear || first) ? BBOX_EMPTY : bbox_reg;
    count_base = (clear || first) ? '0 : count_reg;
    bbox_next  = bbox_base;
    count_next = count_base;
    if (hit && !clear) begin
      if (row < bbox_base.row_min) bbox_next.row_min = row;
      if (row > bbox_base.row_max) bbox_next.row_max = row;
      if (col < bbox_base.col_min) bbox_next.col_min = col;
      if (col > bbox_base.col_max) bbox_next.col_max = col;
      if (count_base != '1) count_next = count_base + CNT_W'(1);
    end
  end

  // Accumulator state; reset leaves an empty box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_reg  <= BBOX_EMPTY;
      count_reg <= '0;
    end else begin
      bbox_reg  <= bbox_next;
      count_reg <= count_next;
    end
  end

  assign bbox  = bbox_reg;
  assign count = count_reg;

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Paddle bounding-box tracker. Takes the two-colour mask stream, builds a
// bounding box and pixel count per colour over each frame, and at frame end
// publishes a found flag and centre point per paddle.
// Optional: define PADDLE_BBOX_EXPORT_EN to also export the raw boxes on
// p1_bbox / p2_bbox.
module paddle_bbox_tracker
  import paddle_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        enc_valid,
  input  logic [1:0]  color_enc,
  input  logic [10:0] row,
  input  logic [11:0] col,
  output logic        result_valid,
  output logic        p1_found,
  output logic [10:0] p1_row_c,
  output logic [11:0] p1_col_c,
  output logic        p2_found,
  output logic [10:0] p2_row_c,
  output logic [11:0] p2_col_c,
  output logic        frame_err
`ifdef PADDLE_BBOX_EXPORT_EN
  ,
  output logic [45:0] p1_bbox,
  output logic [45:0] p2_bbox
`endif
);

  // Stage-0 pipeline: qualified pixel and its colour hits.
  logic             pix_in_range;
  logic [1:0]       hit_in;
  logic             s0_valid_reg;
  logic [1:0]       s0_hit_reg;
  logic             s0_first_reg;
  logic             s0_last_reg;
  logic [ROW_W-1:0] s0_row_reg;
  logic [COL_W-1:0] s0_col_reg;

  tracker_state_t   state_reg, state_next;
  logic             acc_clear, acc_first, acc_en, frame_abort;
  logic             publish;
  logic             frame_err_reg;

  logic [1:0]       found_out;
  logic [ROW_W-1:0] row_c_out [2];
  logic [COL_W-1:0] col_c_out [2];
`ifdef PADDLE_BBOX_EXPORT_EN
  logic [BBOX_W-1:0] bbox_out [2];
`endif

  assign pix_in_range = (int'(row) < V_ACTIVE) && (int'(col) < H_ACTIVE);
  // A disabled encoding reads as ENC_NONE.
  assign hit_in[0] = enc_valid && ((color_enc == ENC_C1) || (color_enc == ENC_BOTH));
  assign hit_in[1] = enc_valid && ((color_enc == ENC_C2) || (color_enc == ENC_BOTH));

  // Register the qualified pixel plus frame start/end markers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_reg <= 1'b0;
      s0_hit_reg   <= 2'b00;
      s0_first_reg <= 1'b0;
      s0_last_reg  <= 1'b0;
      s0_row_reg   <= '0;
      s0_col_reg   <= '0;
    end else begin
      s0_valid_reg <= pix_valid && pix_in_range;
      s0_hit_reg   <= hit_in;
      s0_first_reg <= (row == '0) && (col == '0);
      s0_last_reg  <= (int'(row) == V_ACTIVE - 1) && (int'(col) == H_ACTIVE - 1);
      s0_row_reg   <= row;
      s0_col_reg   <= col;
    end
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Frame sequencing: start on (0,0), publish after the last pixel,
  // restart (and flag an error) on an early (0,0).
  always_comb begin
    state_next  = state_reg;
    acc_clear   = 1'b0;
    acc_first   = 1'b0;
    acc_en      = 1'b0;
    frame_abort = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s0_valid_reg && s0_first_reg) begin
          acc_first  = 1'b1;
          acc_en     = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (s0_valid_reg) begin
          acc_en = 1'b1;
          if (s0_first_reg) begin
            acc_first   = 1'b1;
            frame_abort = 1'b1;
          end else if (s0_last_reg) begin
            state_next = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        acc_clear  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign publish = (state_reg == PUBLISH);

  // Abort pulse is registered so it is a clean one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_reg <= 1'b0;
    else        frame_err_reg <= frame_abort;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_color
      bbox_t            bb;
      logic [CNT_W-1:0] cnt;
      logic             found_now, found_reg;
      logic [ROW_W-1:0] row_c_now, row_c_reg;
      logic [COL_W-1:0] col_c_now, col_c_reg;

      bbox_accum #(.CNT_W(CNT_W)) u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .first (acc_first),
        .hit   (acc_en && s0_hit_reg[gi]),
        .row   (s0_row_reg),
        .col   (s0_col_reg),
        .bbox  (bb),
        .count (cnt)
      );

      assign found_now = (cnt >= CNT_W'(MIN_PIXELS));
      assign row_c_now = found_now ? mid_row(bb.row_min, bb.row_max) : '0;
      assign col_c_now = found_now ? mid_col(bb.col_min, bb.col_max) : '0;

      // Hold the published result until the next frame completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          found_reg <= 1'b0;
          row_c_reg <= '0;
          col_c_reg <= '0;
        end else if (publish) begin
          found_reg <= found_now;
          row_c_reg <= row_c_now;
          col_c_reg <= col_c_now;
        end
      end

      // During PUBLISH the fresh values are shown alongside result_valid.
      assign found_out[gi] = publish ? found_now : found_reg;
      assign row_c_out[gi] = publish ? row_c_now : row_c_reg;
      assign col_c_out[gi] = publish ? col_c_now : col_c_reg;

`ifdef PADDLE_BBOX_EXPORT_EN
      logic [BBOX_W-1:0] bbox_now, bbox_reg;
      assign bbox_now = found_now ? bb : '0;

      // Exported box follows the same publish/hold timing as the centres.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       bbox_reg <= '0;
        else if (publish) bbox_reg <= bbox_now;
      end

      assign bbox_out[gi] = publish ? bbox_now : bbox_reg;
`endif
    end
  endgenerate

  assign result_valid = publish;
  assign frame_err    = frame_err_reg;
  assign p1_found     = found_out[0];
  assign p1_row_c     = row_c_out[0];
  assign p1_col_c     = col_c_out[0];
  assign p2_found     = found_out[1];
  assign p2_row_c     = row_c_out[1];
  assign p2_col_c     = col_c_out[1];
`ifdef PADDLE_BBOX_EXPORT_EN
  assign p1_bbox      = bbox_out[0];
  assign p2_bbox      = bbox_out[1];
`endif

endmodule

// File: doc/paddle_bbox_tracker.md
Name: paddle_bbox_tracker

Overview:
- Consumes the per-pixel two-colour mask stream produced by paddle localization: 2-bit colour encoding, valid flag and row/col.
- Accumulates a per-frame bounding box and pixel count for each paddle colour.
- At end of frame, publishes a centre point and a found flag per paddle for the game logic and overlay.
- Sits downstream of the colour mask, in the VGA pixel-clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CNT_W, 19, width of the per-colour pixel counter (saturating).
- MIN_PIXELS, 64, minimum count for a paddle to be reported as found.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  row/col/enc are a real pixel this cycle.
- enc_valid  in  1  colour encoding valid; when low the pixel is treated as ENC_NONE.
- color_enc  in  2  01=colour1, 10=colour2, 11=both, 00=none.
- row  in  11  pixel row.
- col  in  12  pixel column.
- result_valid  out  1  one-cycle pulse when new results are published.
- p1_found  out  1  colour-1 count >= MIN_PIXELS.
- p1_row_c  out  11  colour-1 row centre.
- p1_col_c  out  12  colour-1 column centre.
- p2_found, p2_row_c, p2_col_c  out  1/11/12  same fields for colour 2.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Accumulators are cleared: min = all-ones, max = 0, count = 0. Reset mid-frame discards all partial data.
- Pixels with row >= V_ACTIVE or col >= H_ACTIVE are ignored. Cycles with pix_valid low are ignored.
- Stage 0 registers the qualified inputs. Accumulators update one cycle later.
- FSM state IDLE:
  - Waits for a valid pixel at (0,0).
  - On that pixel, loads the accumulators as if the first pixel were fresh, then moves to ACCUM.
- FSM state ACCUM, per colour c (encoding 11 counts toward both colours):
  - If the pixel has colour c: row_min = min(row_min, row), row_max = max(row_max, row), col_min and col_max likewise, count += 1. The count saturates at 2^CNT_W-1.
  - On the pixel at (V_ACTIVE-1, H_ACTIVE-1), after that pixel is accumulated, move to PUBLISH.
  - On a pixel at (0,0) while in ACCUM (frame restarted early): pulse frame_err, publish nothing, clear the accumulators, then accumulate this pixel as the first pixel of the new frame. Stay in ACCUM.
- FSM state PUBLISH (one cycle):
  - found = (count >= MIN_PIXELS).
  - Centre = (min + max) >> 1, computed at width+1 bits so there is no overflow.
  - If not found, that paddle's centre outputs are 0.
  - Pulse result_valid. Clear the accumulators. Return to IDLE.
- Result outputs hold their value until the next PUBLISH.
- Latency: the last pixel is presented in cycle k; result_valid is high in cycle k+2.
- A (0,0) pixel arriving in the PUBLISH cycle is captured by the stage-0 register and processed in IDLE. No pixel is lost.

Optional Feature:
- Macro name: PADDLE_BBOX_EXPORT_EN.
- Defined: adds output ports p1_bbox and p2_bbox, each 46 bits = {row_min 11, row_max 11, col_min 12, col_max 12}. They are latched in PUBLISH alongside the centres and are 0 when not found.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Package paddle_pkg holds:
  - H_ACTIVE_DEF and V_ACTIVE_DEF.
  - ENC_NONE, ENC_C1, ENC_C2 and ENC_BOTH.
  - A typedef bbox_t {row_min, row_max, col_min, col_max}.
  - An enum tracker_state_t {IDLE, ACCUM, PUBLISH}.
- One sub-module, bbox_accum: the per-colour min/max/count accumulator with clear, hit and first-pixel inputs. It is instantiated twice.

Test Plan:
- Full 640x480 frame with a colour-1 rectangle at rows 100-119 and cols 200-239 (800 px) and no colour 2 -> result_valid at k+2, p1_found=1, p1_row_c=109, p1_col_c=219, p2_found=0, p2 centres 0.
- Colour-2 blob of 63 px, then a repeat frame with 64 px -> p2_found=0 in the first frame, then p2_found=1 in the second.
- Pixels encoded 11 over rows 10-11 and cols 0-639 -> both paddles found, row_c=10, col_c=319 for both.
- A frame restarting at (0,0) mid-frame at row 300 -> frame_err pulses once, no result_valid, and the next complete frame publishes only that frame's data.
- rst_n asserted at row 200 of a frame -> all outputs 0 immediately, and no result_valid until one full frame after release.
- enc_valid=0 with color_enc=01 on every pixel, plus out-of-range col=700 pixels carrying colour 1 -> p1_found=0 and p1 centres 0.
